// File: rtl/regfile_onehot.sv
// Register file with one-hot write enable from the address decoder; register 0 reads as zero.
// Define READ_BYPASS_EN to forward same-cycle write data to a matching read port.
module regfile_onehot #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic [(2**AW)-1:0]  iWe,
  input  logic [WIDTH-1:0]    iWData,
  input  logic [AW-1:0]       iRAddr1,
  input  logic [AW-1:0]       iRAddr2,
  output logic [WIDTH-1:0]    oRData1,
  output logic [WIDTH-1:0]    oRData2,
  output logic                oErr
);

  localparam int DEPTH = 2**AW;

  logic [WIDTH-1:0] regs [DEPTH];
  logic             anyHot;
  logic             multiHot;
  logic             singleHot;

  // Clearing the lowest set bit leaves something only when two or more bits were set.
  always_comb begin
    anyHot    = (iWe != '0);
    multiHot  = ((iWe & (iWe - 1'b1)) != '0);
    singleHot = anyHot && !multiHot;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      oErr <= 1'b0;
    end else begin
      oErr <= multiHot;
      for (int i = 1; i < DEPTH; i++) begin
        if (singleHot && iWe[i]) begin
          regs[i] <= iWData;
        end
      end
    end
  end

  always_comb begin
    oRData1 = (iRAddr1 == '0) ? '0 : regs[iRAddr1];
    oRData2 = (iRAddr2 == '0) ? '0 : regs[iRAddr2];
`ifdef READ_BYPASS_EN
    if (singleHot && iWe[iRAddr1] && (iRAddr1 != '0)) begin
      oRData1 = iWData;
    end
    if (singleHot && iWe[iRAddr2] && (iRAddr2 != '0)) begin
      oRData2 = iWData;
    end
`endif
  end

endmodule

// File: tb/tb_regfile_onehot.sv
// Scoreboard bench for regfile_onehot: expectations queued from a behavioural model, popped against outputs.
module tb_regfile_onehot;

  logic        iClk;
  logic        iRst;
  logic [31:0] iWe;
  logic [31:0] iWData;
  logic [4:0]  iRAddr1;
  logic [4:0]  iRAddr2;
  logic [31:0] oRData1;
  logic [31:0] oRData2;
  logic        oErr;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } expEntry;

  expEntry     scoreboard[$];
  logic [31:0] model [32];
  int          checks = 0;
  int          errors = 0;

  regfile_onehot #(.WIDTH(32), .AW(5)) dut (
    .iClk(iClk), .iRst(iRst), .iWe(iWe), .iWData(iWData),
    .iRAddr1(iRAddr1), .iRAddr2(iRAddr2),
    .oRData1(oRData1), .oRData2(oRData2), .oErr(oErr)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic pushExp(input string tag, input logic [31:0] value);
    expEntry e;
    e.tag = tag;
    e.exp = value;
    scoreboard.push_back(e);
  endtask

  task automatic popCompare(input logic [31:0] observed);
    expEntry e;
    if (scoreboard.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = scoreboard.pop_front();
      checkOutput(e.tag, observed, e.exp);
    end
  endtask

  // Expected combinational read value given the current write inputs.
  function automatic logic [31:0] modelRead(input logic [4:0] addr);
    logic [31:0] v;
    v = (addr == 5'd0) ? 32'd0 : model[addr];
`ifdef READ_BYPASS_EN
    if (($countones(iWe) == 1) && iWe[addr] && (addr != 5'd0)) v = iWData;
`endif
    return v;
  endfunction

  task automatic readBoth(input string tag, input logic [4:0] a1, input logic [4:0] a2);
    iRAddr1 = a1;
    iRAddr2 = a2;
    #1;
    pushExp({tag, "_p1"}, modelRead(a1));
    pushExp({tag, "_p2"}, modelRead(a2));
    popCompare(oRData1);
    popCompare(oRData2);
  endtask

  // Drives one write vector across a rising edge, then checks the registered error flag.
  task automatic applyStimulus(input logic [31:0] we, input logic [31:0] data);
    logic expErr;
    iWe    = we;
    iWData = data;
    expErr = ($countones(we) > 1);
    @(posedge iClk);
    if ($countones(we) == 1 && !we[0]) begin
      for (int i = 1; i < 32; i++) if (we[i]) model[i] = data;
    end
    #1;
    pushExp("oErr", {31'd0, expErr});
    popCompare({31'd0, oErr});
    iWe = 32'd0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    iRst = 1'b1; iWe = 32'd0; iWData = 32'd0; iRAddr1 = 5'd0; iRAddr2 = 5'd0;
    repeat (2) @(posedge iClk);
    #1;
    pushExp("rst_oErr", 32'd0);
    popCompare({31'd0, oErr});
    readBoth("rst_read", 5'd5, 5'd31);
    iRst = 1'b0;
    @(posedge iClk); #1;

    // Mid-cycle asynchronous reset after writing reg5
    applyStimulus(32'h0000_0020, 32'hA5A5_A5A5);
    readBoth("pre_rst", 5'd5, 5'd5);
    #2;
    iRst = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    #1;
    readBoth("async_rst", 5'd5, 5'd0);
    pushExp("async_rst_oErr", 32'd0);
    popCompare({31'd0, oErr});
    iWe = 32'h0000_0040; iWData = 32'hCAFE_F00D;
    @(posedge iClk); #1;
    iWe = 32'd0;
    iRst = 1'b0;
    readBoth("write_during_rst", 5'd6, 5'd5);

    // Basic write/read and reg0 protection
    applyStimulus(32'h0000_0008, 32'h1234_5678);
    readBoth("basic", 5'd3, 5'd3);
    applyStimulus(32'h0000_0001, 32'hFFFF_FFFF);
    readBoth("reg0", 5'd0, 5'd3);

    // Illegal multi-bit vectors leave state alone and pulse oErr
    applyStimulus(32'h0000_0080, 32'h0000_0011);
    applyStimulus(32'h0000_0200, 32'h0000_0022);
    applyStimulus(32'h0000_0280, 32'h0000_DEAD);
    readBoth("illegal", 5'd7, 5'd9);
    applyStimulus(32'h0000_0000, 32'h0000_BEEF);
    applyStimulus(32'hFFFF_FFFF, 32'h0BAD_0BAD);
    applyStimulus(32'h8000_0001, 32'h0BAD_0BAD);
    applyStimulus(32'h0000_0000, 32'h0000_0000);
    readBoth("illegal_all", 5'd7, 5'd31);

    // Same-cycle read of write target
    applyStimulus(32'h8000_0000, 32'h0000_0001);
    iWe = 32'h8000_0000; iWData = 32'h0000_0002;
    readBoth("same_cycle", 5'd31, 5'd31);
    iWe = 32'h8000_0008;
    readBoth("same_cycle_illegal", 5'd31, 5'd3);
    iWe = 32'h0000_0001;
    readBoth("same_cycle_reg0", 5'd0, 5'd31);
    iWe = 32'd0;
    applyStimulus(32'h8000_0000, 32'h0000_0002);
    readBoth("after_edge", 5'd31, 5'd30);

    // Sweep every register
    for (int i = 1; i < 32; i++) applyStimulus(32'd1 << i, 32'(i) * 32'h0101_0101);
    for (int i = 0; i < 32; i++) readBoth("sweep", 5'(i), 5'(31 - i));

    if (scoreboard.size() != 0) checkOutput("scoreboard_leftover", 32'(scoreboard.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
